// File: rtl/rep5_word_tx_if.sv
// Word-in / symbol-out handshake bundle for the 5-way repetition transmitter.
// The slave modport is the transmitter side; master is the upstream/downstream peer.
interface rep5_word_tx_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IW    = $clog2(WIDTH + 2)
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       inj_mask;
  logic [IW-1:0]    inj_idx;
  logic [4:0]       out_rep;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport slave (
    input  in_data, in_valid, inj_mask, inj_idx, out_ready,
    output in_ready, out_rep, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, inj_mask, inj_idx, out_ready,
    input  in_ready, out_rep, out_valid, out_last
  );
endinterface

// File: rtl/rep5_word_tx.sv
// Serialises each accepted word LSB first as 5-bit replica symbols plus a final
// even-parity symbol, with optional XOR corruption of one chosen symbol.
module rep5_word_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IW    = $clog2(WIDTH + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  rep5_word_tx_if.slave bus,
  output logic [15:0]   frames_sent
);

  localparam logic [IW-1:0] ParIdx = IW'(WIDTH);

  typedef enum logic {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [4:0]       mask_q, mask_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             par_q, par_d;
  logic [4:0]       rep_q, rep_d;
  logic             last_q, last_d;
  logic [15:0]      frames_q, frames_d;
  logic             accept, sym_hs, frame_done;

  // Symbol c of a frame; an index above WIDTH never matches c, so it disables injection.
  function automatic logic [4:0] symbol(input logic [WIDTH-1:0] data, input logic par,
                                        input logic [IW-1:0] c, input logic [IW-1:0] idx,
                                        input logic [4:0] mask);
    logic [WIDTH-1:0] sh;
    logic             b;
    sh = data >> c;
    b  = (c == ParIdx) ? par : sh[0];
    return {5{b}} ^ ((c == idx) ? mask : 5'b00000);
  endfunction

  assign accept     = (state_q == StIdle) && bus.in_valid;
  assign sym_hs     = (state_q == StSend) && bus.out_ready;
  assign frame_done = sym_hs && (cnt_q == ParIdx);
  assign cnt_inc    = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.in_valid) state_d = StSend;
      StSend: if (frame_done)   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StSend);
    bus.out_rep   = rep_q;
    bus.out_last  = last_q;
    frames_sent   = frames_q;
  end

  // Datapath: the next symbol is computed one cycle ahead so outputs come straight from flops.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    par_d    = par_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    last_d   = last_q;
    frames_d = frames_q;
    if (accept) begin
      data_d = bus.in_data;
      mask_d = bus.inj_mask;
      idx_d  = bus.inj_idx;
      par_d  = ^bus.in_data;
      cnt_d  = '0;
      rep_d  = symbol(bus.in_data, ^bus.in_data, '0, bus.inj_idx, bus.inj_mask);
      last_d = 1'b0;
    end else if (frame_done) begin
      cnt_d    = '0;
      rep_d    = 5'b00000;
      last_d   = 1'b0;
      frames_d = frames_q + 16'd1;
    end else if (sym_hs) begin
      cnt_d  = cnt_inc;
      rep_d  = symbol(data_q, par_q, cnt_inc, idx_q, mask_q);
      last_d = (cnt_inc == ParIdx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
      rep_q    <= 5'b00000;
      last_q   <= 1'b0;
      frames_q <= 16'd0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      last_q   <= last_d;
      frames_q <= frames_d;
    end
  end

endmodule

// File: tb/tb_rep5_word_tx.sv
// Randomised bench for rep5_word_tx: expected symbols come from a per-bit
// replication model of each frame.
module tb_rep5_word_tx;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IW    = $clog2(WIDTH + 2);

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frames_sent;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_frames = 16'd0;

  rep5_word_tx_if #(.WIDTH(WIDTH), .IW(IW)) bus ();

  rep5_word_tx #(.WIDTH(WIDTH), .IW(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Symbol i of a frame: data bit i (or parity of the word), copied five times, maybe corrupted.
  function automatic logic [4:0] ref_sym(input logic [WIDTH-1:0] d, input int i, input int idx,
                                         input logic [4:0] m);
    int ones = 0;
    int b;
    for (int k = 0; k < WIDTH; k++) ones += int'(d[k]);
    if (i < WIDTH) b = int'((d >> i) & 1);
    else b = ones % 2;
    ref_sym = (b == 1) ? 5'b11111 : 5'b00000;
    if (i == idx) ref_sym = ref_sym ^ m;
  endfunction

  // mode 0: out_ready always high; 1: random stalls; 2: three stalls on symbol 0
  task automatic send_word(input logic [WIDTH-1:0] d, input logic [4:0] m, input int idx,
                           input int mode);
    int stalls;
    check_eq("in_ready_idle", bus.in_ready, 1);
    bus.in_data  = d;
    bus.inj_mask = m;
    bus.inj_idx  = IW'(idx);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = WIDTH'($urandom);
    bus.inj_mask = 5'($urandom);
    bus.inj_idx  = IW'($urandom);
    for (int i = 0; i <= WIDTH; i++) begin
      stalls = 0;
      forever begin
        if (mode == 2 && i == 0) bus.out_ready = (stalls >= 3);
        else if (mode == 1) bus.out_ready = (stalls >= 3) || ($urandom_range(0, 1) == 1);
        else bus.out_ready = 1'b1;
        check_eq("out_valid", bus.out_valid, 1);
        check_eq("in_ready_busy", bus.in_ready, 0);
        check_eq($sformatf("rep[%0d]", i), bus.out_rep, ref_sym(d, i, idx, m));
        check_eq("out_last", bus.out_last, (i == WIDTH) ? 1 : 0);
        @(negedge clk);
        if (bus.out_ready) break;
        stalls++;
      end
    end
    bus.out_ready = 1'($urandom_range(0, 1));
    exp_frames = exp_frames + 16'd1;
    check_eq("frames_sent", frames_sent, exp_frames);
    check_eq("in_ready_after", bus.in_ready, 1);
    check_eq("out_valid_after", bus.out_valid, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_in_ready"}, bus.in_ready, 1);
    check_eq({tag, "_out_valid"}, bus.out_valid, 0);
    check_eq({tag, "_out_last"}, bus.out_last, 0);
    check_eq({tag, "_out_rep"}, bus.out_rep, 0);
    check_eq({tag, "_frames"}, frames_sent, 0);
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.inj_mask  = '0;
    bus.inj_idx   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("after_reset");

    send_word(8'hA5, 5'b00000, 15, 0);
    @(negedge clk);
    send_word(8'h01, 5'b00000, 15, 2);
    send_word(8'hA5, 5'b00011, 2, 0);
    send_word(8'hA5, 5'b10000, 8, 1);
    send_word(8'hA5, 5'b11111, 9, 0);
    for (int n = 0; n < 40; n++) begin
      send_word(WIDTH'($urandom), 5'($urandom), int'($urandom_range(0, 15)), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Abort a frame after four symbol handshakes.
    bus.in_data  = 8'h33;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_state("mid_reset");
    exp_frames = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(8'hFF, 5'b00000, 15, 0);

    // Preload the frame counter to its maximum.
    @(negedge clk);
    force dut.frames_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.frames_q;
    exp_frames = 16'hFFFF;
    check_eq("frames_preload", frames_sent, exp_frames);
    send_word(8'h5A, 5'b00000, 15, 1);
    check_eq("frames_wrapped", frames_sent, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rep5_word_tx.md
# rep5_word_tx

Transmit side of the 5-way repetition/majority link. The block accepts parallel data words over a valid/ready handshake and serialises each word, LSB first, as a stream of 5-bit replica symbols followed by one even-parity symbol. A 5-input majority voter downstream recovers each bit from its symbol. A per-word fault-injection mask corrupts a chosen symbol so that voter tolerance can be exercised in-system.

## Interface
- WIDTH, 8: data word width; legal range 2..64.
- IW, $clog2(WIDTH+2): width of the injection index.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to transmit.
- in_valid  input  1  in_data, inj_mask and inj_idx are valid.
- in_ready  output  1  block can accept a word.
- inj_mask  input  5  XOR mask applied to the selected symbol; 0 means no corruption.
- inj_idx  input  IW  symbol index to corrupt: 0..WIDTH-1 are data bits, WIDTH is parity; any value greater than WIDTH disables injection.
- out_rep  output  5  current replica symbol.
- out_valid  output  1  out_rep is valid.
- out_ready  input  1  downstream accepts the symbol.
- out_last  output  1  current symbol is the parity symbol, which is the last of the frame.
- frames_sent  output  16  count of completed frames; wraps modulo 2^16.

## Operation
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch in_data, inj_mask and inj_idx; compute par = ^in_data (even parity); set cnt=0; go to SEND.
- State SEND:
  - in_ready=0, out_valid=1.
  - bit = data[cnt] when cnt<WIDTH; bit = par when cnt==WIDTH.
  - out_rep = {5{bit}} ^ (cnt==inj_idx ? mask : 5'b0).
  - out_last = (cnt==WIDTH).
- Symbol handshake in SEND:
  - On out_valid & out_ready with cnt<WIDTH: cnt increments.
  - On the handshake with cnt==WIDTH: frames_sent increments (0xFFFF wraps to 0x0000); go to IDLE.
- While out_valid=1 and out_ready=0: out_rep, out_last and cnt hold stable. Upstream input changes are ignored because the word is latched.
- in_data/inj_* changes outside an accepting handshake have no effect.
- cnt width is IW; cnt never exceeds WIDTH.
- out_rep, out_valid and out_last are driven from registers: no combinational path from any input to any output. in_ready is a decode of the state register.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_rep=5'b00000, frames_sent=0, state=IDLE, cnt=0.
- Reset is asynchronous: asserting rst_n low mid-frame forces the reset values immediately and discards the frame. frames_sent does not count the discarded frame.
- Latency: a word accepted at edge k gives out_valid=1 with symbol 0 during the cycle after edge k.
- Frame length: WIDTH+1 symbol handshakes. With out_ready held high, the frame occupies WIDTH+1 consecutive cycles.
- After the last handshake the block spends one cycle in IDLE (in_ready=1) before it can accept the next word. Peak throughput is therefore one word per WIDTH+2 cycles.
- in_ready and out_valid are never both 1.

## Test plan
- Reset: hold rst_n=0, then release. Required: in_ready=1, out_valid=0, out_rep=00000, frames_sent=0.
- Basic frame, WIDTH=8, in_data=0xA5, inj_mask=0, out_ready=1:
  - out_rep sequence 11111, 00000, 11111, 00000, 00000, 11111, 00000, 11111, then 00000 (parity) with out_last=1.
  - frames_sent then reads 1, and in_ready=1 in the following cycle.
- Backpressure: data 0x01 with out_ready=0 for 3 cycles at symbol 0. Required: out_rep=11111 and out_valid=1 held stable for all 3 cycles; cnt advances only on handshake; total of 9 handshakes.
- Injection, data 0xA5:
  - inj_mask=00011, inj_idx=2: only symbol 2 is 11100; all other symbols match the basic frame.
  - inj_idx=8, mask=10000: parity symbol is 10000.
  - inj_idx=9: no corruption.
- Reset mid-frame: assert rst_n low after 4 symbol handshakes. Required: outputs return to reset values at once and frames_sent stays 0. A new word 0xFF afterwards sends eight 11111 symbols, then parity 00000.
- Counter wrap: preload by sending 65536 frames (or force frames_sent=0xFFFF). Required: the next frame completion gives frames_sent=0x0000.
